conv_enc: RTL and testbench

- Rate-1/2, constraint-length-4 (8-state) convolutional encoder: the transmit-side counterpart of the Viterbi decoder's traceback unit.
- Accepts a frame of information bits and emits one 2-bit code symbol per bit. Appends 3 zero tail bits so every frame terminates in trellis state 0, where decoder traceback starts.
- Uses valid/ready handshakes on both sides so it can feed a channel model or decoder input FIFO that applies backpressure.

---
 rtl/conv_enc.sv | 154 +++++++++++++++
 tb/tb_conv_enc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_enc: rate-1/2, K=4 convolutional encoder with zero-tail termination
// Rev 1.0
// ----------------------------------------------------------------------------
module conv_enc #(
  parameter int          LEN_W = 8,
  parameter logic [3:0]  G0    = 4'b1111,
  parameter logic [3:0]  G1    = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             d_in,
  input  logic             d_in_valid,
  output logic             d_in_ready,
  output logic [1:0]       code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_TAIL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tail_q, tail_d;
  logic [2:0]       sr_q, sr_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             free;
  logic             load;
  logic             bit_in;
  logic [3:0]       v;
  logic             p0, p1;

  assign free       = !valid_q || code_ready;
  assign d_in_ready = (state_q == S_DATA) && free;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    sr_d    = sr_q;
    code_d  = code_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    bit_in  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d   = frame_len;
          sr_d    = 3'b000;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (d_in_valid && free) begin
          load   = 1'b1;
          bit_in = d_in;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            tail_d  = 2'd0;
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        // Flushing zeros walks the trellis back to state 0 in three steps.
        if (free) begin
          load   = 1'b1;
          tail_d = tail_q + 2'd1;
          if (tail_q == 2'd2) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!valid_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    v  = {bit_in, sr_q};
    p0 = ^(v & G0);
    p1 = ^(v & G1);

    if (load) begin
      sr_d    = {bit_in, sr_q[2:1]};
      code_d  = {p1, p0};
      valid_d = 1'b1;
    end else if (valid_q && code_ready) begin
      valid_d = 1'b0;
    end

    if (!enable) begin
      state_d = S_IDLE;
      len_d   = '0;
      cnt_d   = '0;
      tail_d  = 2'd0;
      sr_d    = 3'b000;
      code_d  = 2'b00;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= 2'd0;
      sr_q    <= 3'b000;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      sr_q    <= sr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_enc: randomized self-checking bench for conv_enc
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_conv_enc;

  localparam int         LEN_W = 8;
  localparam logic [3:0] TG0   = 4'b1111;
  localparam logic [3:0] TG1   = 4'b1101;
  localparam int         BUDGET = 5000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             d_in = 1'b0;
  logic             d_in_valid = 1'b0;
  logic             d_in_ready;
  logic [1:0]       code_out;
  logic             code_valid;
  logic             code_ready = 1'b1;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  logic       bits [0:255];
  int         cur_len;
  logic [1:0] got_q [$];
  logic       prev_stall = 1'b0;
  logic [1:0] prev_code  = 2'b00;

  conv_enc #(.LEN_W(LEN_W), .G0(TG0), .G1(TG1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .frame_len(frame_len),
    .d_in(d_in), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Symbol k is the parity of the tapped bits among the last four inputs of the
  // zero-padded message (message followed by three zeros, zeros before it).
  function automatic logic [1:0] exp_sym(input int k);
    logic a, b, u;
    int   idx;
    a = 1'b0;
    b = 1'b0;
    for (int j = 0; j < 4; j++) begin
      idx = k - j;
      u = (idx >= 0 && idx < cur_len) ? bits[idx] : 1'b0;
      if (TG0[3-j]) a = a ^ u;
      if (TG1[3-j]) b = b ^ u;
    end
    return {b, a};
  endfunction

  // Output-side monitor: captures transfers and checks handshake rules.
  always @(negedge clk) begin
    if (rst && enable) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, code_valid}, 32'd1);
        check("stall_code", {30'd0, code_out}, {30'd0, prev_code});
      end
      check("rdy_needs_free", {31'd0, d_in_ready & code_valid & ~code_ready}, 32'd0);
      if (!busy) check("rdy_idle", {31'd0, d_in_ready}, 32'd0);
      if (code_valid && code_ready) got_q.push_back(code_out);
      prev_stall <= code_valid && !code_ready;
      prev_code  <= code_out;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic run_frame(input string name, input int len, input int vmode, input int vpct,
                           input int rpct, input int stall_after, input bit mid_start);
    int         idx, cyc, stall_cnt;
    bit         dn;
    logic [6:0] vpat;
    vpat = 7'b1011001;
    cur_len = len;
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(len);
    d_in_valid = 1'b0;
    code_ready = 1'b1;
    idx = 0; cyc = 0; stall_cnt = 0; dn = 1'b0;
    while (!dn && cyc < BUDGET) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid_start && cyc == 2) begin
        start = 1'b1;
        frame_len = LEN_W'(5);
      end
      if (vmode == 1) d_in_valid = (idx < len) && vpat[cyc % 7];
      else            d_in_valid = (idx < len) && ($urandom_range(99) < vpct);
      d_in = (idx < len) ? bits[idx] : 1'b0;
      code_ready = ($urandom_range(99) < rpct);
      if (stall_after >= 0 && got_q.size() == stall_after && stall_cnt < 3) begin
        code_ready = 1'b0;
        stall_cnt++;
      end
      @(negedge clk);
      if (d_in_valid && d_in_ready) idx++;
      if (done) begin
        dn = 1'b1;
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
      cyc++;
    end
    d_in_valid = 1'b0;
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, dn}, 32'd1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_nsym"}, got_q.size(), len + 3);
    for (int k = 0; k < got_q.size() && k < len + 3; k++)
      check($sformatf("%s_sym%0d", name, k), {30'd0, got_q[k]}, {30'd0, exp_sym(k)});
  endtask

  task automatic set_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) bits[i] = v[n-1-i];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bits[i] = 1'b0;
    #12;
    check("rst_valid", {31'd0, code_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_code", {30'd0, code_out}, 32'd0);
    check("rst_rdy", {31'd0, d_in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    set_bits(32'b1, 1);
    run_frame("impulse", 1, 0, 100, 100, -1, 1'b0);
    check("impulse_first", {30'd0, exp_sym(0)}, 32'd3);

    set_bits(32'b1011, 4);
    run_frame("pattern", 4, 0, 100, 100, -1, 1'b0);
    run_frame("bkpress", 4, 0, 100, 100, 2, 1'b0);
    run_frame("gaps", 4, 1, 0, 100, -1, 1'b0);
    run_frame("midstart", 4, 0, 100, 100, -1, 1'b1);

    // start with zero length must be ignored
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_valid", {31'd0, code_valid}, 32'd0);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) bits[i] = 1'($urandom_range(1));
      run_frame($sformatf("rand%0d", f), n, 0, 60, 60, -1, 1'b0);
    end
    for (int i = 0; i < 255; i++) bits[i] = 1'($urandom_range(1));
    run_frame("maxlen", 255, 0, 80, 80, -1, 1'b0);

    // synchronous clear mid-frame
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(10);
    code_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d_in_valid = 1'b1;
    d_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check("en_busy", {31'd0, busy}, 32'd0);
    check("en_valid", {31'd0, code_valid}, 32'd0);
    for (int i = 0; i < 256; i++) bits[i] = 1'b0;
    set_bits(32'b1, 1);
    run_frame("after_en", 1, 0, 100, 100, -1, 1'b0);

    // asynchronous reset while flushing the tail
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(2);
    code_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d_in_valid = 1'b1;
    d_in = 1'b1;
    @(posedge clk); #1;
    d_in = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(posedge clk); #2;
    check("tail_busy", {31'd0, busy}, 32'd1);
    check("tail_valid", {31'd0, code_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, code_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_code", {30'd0, code_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_bits(32'b1, 1);
    run_frame("after_arst", 1, 0, 100, 100, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
